led_p2s_driver: RTL and testbench

- Downstream consumer of the 16-bit four-nibble counter value produced by the button-driven number generator.
- On each start request, captures the value and encodes every nibble to a common-anode 7-segment hex glyph.
- Shifts the resulting 32-bit frame MSB-first into an external 74HC595-style shift-register chain, then pulses the storage latch.
- Sits between the number generator and the board's serial LED connector.

---
 rtl/led_p2s_driver_if.sv | 21 ++
 rtl/led_p2s_driver.sv | 121 ++++++++++++
 tb/tb_led_p2s_driver.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/led_p2s_driver_if.sv
// rtl/led_p2s_driver_if.sv - request/status and serial LED link bundle for led_p2s_driver
interface led_p2s_driver_if;
  logic [15:0] num;
  logic [3:0]  dp;
  logic        start;
  logic        busy;
  logic        done;
  logic        sclk;
  logic        sdata;
  logic        slatch;

  modport master (
    output num, dp, start,
    input  busy, done, sclk, sdata, slatch
  );

  modport slave (
    input  num, dp, start,
    output busy, done, sclk, sdata, slatch
  );
endinterface

// File: rtl/led_p2s_driver.sv
// rtl/led_p2s_driver.sv - hex-to-7-segment encoder and 74HC595 serial frame shifter
module led_p2s_driver #(
  parameter int CLK_DIV = 2
) (
  input logic             clk,
  input logic             rst_n,
  led_p2s_driver_if.slave bus
);

  typedef enum logic [1:0] {IDLE, SHIFT_LO, SHIFT_HI, LATCH} state_t;

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

  state_t      r_state, w_state_nxt;
  logic [31:0] r_frame, w_frame_nxt;
  logic [4:0]  r_bit,   w_bit_nxt;
  logic [7:0]  r_div,   w_div_nxt;
  logic        r_done,  w_done_nxt;
  logic        w_phase_end;

  // Common-anode glyph: segments active-low, bit 7 is the inverted decimal point.
  function automatic logic [7:0] glyph(input logic [3:0] d, input logic p);
    logic [6:0] seg;
    case (d)
      4'h0: seg = 7'h40;
      4'h1: seg = 7'h79;
      4'h2: seg = 7'h24;
      4'h3: seg = 7'h30;
      4'h4: seg = 7'h19;
      4'h5: seg = 7'h12;
      4'h6: seg = 7'h02;
      4'h7: seg = 7'h78;
      4'h8: seg = 7'h00;
      4'h9: seg = 7'h10;
      4'hA: seg = 7'h08;
      4'hB: seg = 7'h03;
      4'hC: seg = 7'h46;
      4'hD: seg = 7'h21;
      4'hE: seg = 7'h06;
      default: seg = 7'h0E;
    endcase
    return {~p, seg};
  endfunction

  assign w_phase_end = (r_div == DIV_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_frame <= '0;
      r_bit   <= '0;
      r_div   <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_frame <= w_frame_nxt;
      r_bit   <= w_bit_nxt;
      r_div   <= w_div_nxt;
      r_done  <= w_done_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_frame_nxt = r_frame;
    w_bit_nxt   = r_bit;
    w_div_nxt   = r_div;
    w_done_nxt  = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.start) begin
          w_frame_nxt = {glyph(bus.num[15:12], bus.dp[3]),
                         glyph(bus.num[11:8],  bus.dp[2]),
                         glyph(bus.num[7:4],   bus.dp[1]),
                         glyph(bus.num[3:0],   bus.dp[0])};
          w_bit_nxt   = 5'd31;
          w_div_nxt   = '0;
          w_state_nxt = SHIFT_LO;
        end
      end
      SHIFT_LO: begin
        if (w_phase_end) begin
          w_div_nxt   = '0;
          w_state_nxt = SHIFT_HI;
        end else begin
          w_div_nxt = r_div + 8'd1;
        end
      end
      SHIFT_HI: begin
        if (w_phase_end) begin
          w_div_nxt = '0;
          if (r_bit == 5'd0) begin
            w_state_nxt = LATCH;
          end else begin
            w_bit_nxt   = r_bit - 5'd1;
            w_state_nxt = SHIFT_LO;
          end
        end else begin
          w_div_nxt = r_div + 8'd1;
        end
      end
      default: begin
        // LATCH: done rises together with the return to IDLE.
        if (w_phase_end) begin
          w_div_nxt   = '0;
          w_done_nxt  = 1'b1;
          w_state_nxt = IDLE;
        end else begin
          w_div_nxt = r_div + 8'd1;
        end
      end
    endcase
  end

  assign bus.busy   = (r_state != IDLE);
  assign bus.done   = r_done;
  assign bus.sclk   = (r_state == SHIFT_HI);
  assign bus.slatch = (r_state == LATCH);
  assign bus.sdata  = ((r_state == SHIFT_LO) || (r_state == SHIFT_HI)) ? r_frame[r_bit] : 1'b0;

endmodule

// File: tb/tb_led_p2s_driver.sv
// tb/tb_led_p2s_driver.sv - directed self-checking bench for led_p2s_driver
module tb_led_p2s_driver;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] num = '0;
  logic [3:0]  dp = '0;
  logic        start = 1'b0;
  logic        sel = 1'b0;
  int          total = 0;
  int          bad = 0;

  always #5 clk = ~clk;

  led_p2s_driver_if bus_a();
  led_p2s_driver_if bus_b();

  assign bus_a.num   = num;
  assign bus_a.dp    = dp;
  assign bus_a.start = start & ~sel;
  assign bus_b.num   = num;
  assign bus_b.dp    = dp;
  assign bus_b.start = start & sel;

  led_p2s_driver #(.CLK_DIV(2)) u_dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a.slave));
  led_p2s_driver #(.CLK_DIV(1)) u_dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b.slave));

  logic m_busy, m_done, m_sclk, m_sdata, m_slatch;
  assign m_busy   = sel ? bus_b.busy   : bus_a.busy;
  assign m_done   = sel ? bus_b.done   : bus_a.done;
  assign m_sclk   = sel ? bus_b.sclk   : bus_a.sclk;
  assign m_sdata  = sel ? bus_b.sdata  : bus_a.sdata;
  assign m_slatch = sel ? bus_b.slatch : bus_a.slatch;

  // Launches one frame on the selected instance and records what appears on the serial pins.
  task automatic capture(input logic hold, input logic scramble, input logic mid_pulse,
                         output logic [31:0] bits, output int rises, output int hi_cnt,
                         output int latch_cyc, output int latch_sd_bad,
                         output int done_at, output logic busy_at_done);
    logic prev;
    int   k;
    bits = '0; rises = 0; hi_cnt = 0; latch_cyc = 0; latch_sd_bad = 0;
    done_at = -1; busy_at_done = 1'bx; prev = 1'b0;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    k = 0;
    while (k < 400) begin
      @(negedge clk);
      if (!hold) start = 1'b0;
      if (mid_pulse && k == 40) start = 1'b1;
      if (scramble) begin
        num = 16'($urandom);
        dp  = 4'($urandom);
      end
      if (m_sclk && !prev) begin
        bits  = {bits[30:0], m_sdata};
        rises = rises + 1;
      end
      if (m_sclk) hi_cnt = hi_cnt + 1;
      prev = m_sclk;
      if (m_slatch) begin
        latch_cyc = latch_cyc + 1;
        if (m_sdata) latch_sd_bad = latch_sd_bad + 1;
      end
      if (m_done) begin
        done_at = k;
        busy_at_done = m_busy;
        break;
      end
      @(posedge clk);
      k = k + 1;
    end
    if (done_at < 0) $display("FAIL capture_timeout: no done within %0d cycles", k);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if ({bus_a.busy, bus_a.done, bus_a.sclk, bus_a.sdata, bus_a.slatch} !== 5'b0) begin
      bad++;
      $display("FAIL reset_outs_a: got %b want 00000",
               {bus_a.busy, bus_a.done, bus_a.sclk, bus_a.sdata, bus_a.slatch});
    end
    total++;
    if ({bus_b.busy, bus_b.done, bus_b.sclk, bus_b.sdata, bus_b.slatch} !== 5'b0) begin
      bad++;
      $display("FAIL reset_outs_b: got %b want 00000",
               {bus_b.busy, bus_b.done, bus_b.sclk, bus_b.sdata, bus_b.slatch});
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    logic [31:0] bits; int rises, hi, lc, lsb, d; logic bd;
    sel = 1'b0; num = 16'h0123; dp = 4'b0000;
    capture(1'b0, 1'b0, 1'b0, bits, rises, hi, lc, lsb, d, bd);
    total++; if (bits !== 32'hC0F9A4B0) begin bad++; $display("FAIL basic_bits: got %h want c0f9a4b0", bits); end
    total++; if (rises !== 32) begin bad++; $display("FAIL basic_rises: got %0d want 32", rises); end
    total++; if (hi !== 64) begin bad++; $display("FAIL basic_sclk_hi: got %0d want 64", hi); end
    total++; if (lc !== 2) begin bad++; $display("FAIL basic_latch_len: got %0d want 2", lc); end
    total++; if (lsb !== 0) begin bad++; $display("FAIL basic_latch_sdata: got %0d want 0", lsb); end
    total++; if (d !== 130) begin bad++; $display("FAIL basic_done_at: got %0d want 130", d); end
    total++; if (bd !== 1'b0) begin bad++; $display("FAIL basic_busy_at_done: got %b want 0", bd); end
    @(negedge clk);
    total++;
    if ({m_busy, m_done, m_sdata} !== 3'b000) begin
      bad++; $display("FAIL basic_idle_after: got %b want 000", {m_busy, m_done, m_sdata});
    end
  endtask

  task automatic test_hex_dp();
    logic [31:0] bits; int rises, hi, lc, lsb, d; logic bd;
    sel = 1'b0; num = 16'hABCD; dp = 4'b1010;
    capture(1'b0, 1'b0, 1'b0, bits, rises, hi, lc, lsb, d, bd);
    total++; if (bits !== 32'h088346A1) begin bad++; $display("FAIL hex_bits: got %h want 088346a1", bits); end
    total++; if (d !== 130) begin bad++; $display("FAIL hex_done_at: got %0d want 130", d); end
  endtask

  task automatic test_stability();
    logic [31:0] bits; int rises, hi, lc, lsb, d, busy_seen; logic bd;
    sel = 1'b0; num = 16'h4567; dp = 4'b0101;
    capture(1'b0, 1'b1, 1'b1, bits, rises, hi, lc, lsb, d, bd);
    total++; if (bits !== 32'h99128278) begin bad++; $display("FAIL stab_bits: got %h want 99128278", bits); end
    total++; if (d !== 130) begin bad++; $display("FAIL stab_done_at: got %0d want 130", d); end
    busy_seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (m_busy) busy_seen++;
    end
    total++; if (busy_seen !== 0) begin bad++; $display("FAIL stab_no_second_frame: busy cycles %0d want 0", busy_seen); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] bits; int rises, hi, lc, lsb, d, n, r2, busy_seen; logic bd, prev;
    sel = 1'b0; num = 16'h89EF; dp = 4'b0000;
    capture(1'b1, 1'b0, 1'b0, bits, rises, hi, lc, lsb, d, bd);
    total++; if (bits !== 32'h8090868E) begin bad++; $display("FAIL b2b_bits: got %h want 8090868e", bits); end
    total++; if (bd !== 1'b0) begin bad++; $display("FAIL b2b_busy_at_done: got %b want 0", bd); end
    @(posedge clk);
    @(negedge clk);
    total++;
    if ({m_busy, m_sclk, m_sdata, m_done} !== 4'b1010) begin
      bad++; $display("FAIL b2b_restart: busy/sclk/sdata/done got %b want 1010", {m_busy, m_sclk, m_sdata, m_done});
    end
    n = 1; r2 = 0; prev = 1'b0;
    while (n < 400) begin
      if (m_sclk && !prev) r2++;
      prev = m_sclk;
      if (m_done) break;
      @(posedge clk);
      n++;
      @(negedge clk);
    end
    start = 1'b0;
    total++; if (n !== 131) begin bad++; $display("FAIL b2b_second_done: got %0d want 131", n); end
    total++; if (r2 !== 32) begin bad++; $display("FAIL b2b_second_rises: got %0d want 32", r2); end
    busy_seen = 0;
    repeat (5) begin
      @(negedge clk);
      if (m_busy) busy_seen++;
    end
    total++; if (busy_seen !== 0) begin bad++; $display("FAIL b2b_stop: busy cycles %0d want 0", busy_seen); end
  endtask

  task automatic test_reset_midframe();
    int n, bad_seen;
    sel = 1'b0; num = 16'h0123; dp = 4'b0000;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    n = 0;
    while (!m_sclk && n < 50) begin
      @(negedge clk);
      n++;
    end
    total++; if (m_sclk !== 1'b1) begin bad++; $display("FAIL rstmid_reach_hi: sclk %b want 1", m_sclk); end
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({m_busy, m_done, m_sclk, m_sdata, m_slatch} !== 5'b0) begin
      bad++; $display("FAIL rstmid_async_outs: got %b want 00000", {m_busy, m_done, m_sclk, m_sdata, m_slatch});
    end
    @(negedge clk); rst_n = 1'b1;
    bad_seen = 0;
    repeat (200) begin
      @(negedge clk);
      if (m_slatch || m_busy || m_done) bad_seen++;
    end
    total++; if (bad_seen !== 0) begin bad++; $display("FAIL rstmid_quiet: active cycles %0d want 0", bad_seen); end
  endtask

  task automatic test_div1();
    logic [31:0] bits; int rises, hi, lc, lsb, d; logic bd;
    sel = 1'b1; num = 16'hFFFF; dp = 4'b0000;
    capture(1'b0, 1'b0, 1'b0, bits, rises, hi, lc, lsb, d, bd);
    total++; if (bits !== 32'h8E8E8E8E) begin bad++; $display("FAIL div1_bits: got %h want 8e8e8e8e", bits); end
    total++; if (rises !== 32) begin bad++; $display("FAIL div1_rises: got %0d want 32", rises); end
    total++; if (hi !== 32) begin bad++; $display("FAIL div1_sclk_hi: got %0d want 32", hi); end
    total++; if (lc !== 1) begin bad++; $display("FAIL div1_latch_len: got %0d want 1", lc); end
    total++; if (d !== 65) begin bad++; $display("FAIL div1_done_at: got %0d want 65", d); end
    sel = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_hex_dp();
    test_stability();
    test_back_to_back();
    test_reset_midframe();
    test_div1();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
